// File: rtl/clock_display_pkg.sv
// Shared types and constants for the clock display path.
// Blank code, set-field encodings and refresh FSM states.
package clock_display_pkg;

  // Decodes to all segments off in bcd_to_7seg.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    FIELD_NONE    = 2'd0,
    FIELD_HOURS   = 2'd1,
    FIELD_MINUTES = 2'd2,
    FIELD_SECONDS = 2'd3
  } set_field_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_e;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/hours_12h_conv.sv
// 24 h BCD hours to 12 h BCD hours with PM flag.
// Invalid input reports valid=0, pm=0 and blank digits.
module hours_12h_conv
  import clock_display_pkg::*;
(
  input  logic [7:0] hours_bcd,
  output logic [7:0] hours_12_bcd,
  output logic       pm,
  output logic       valid
);

  logic [6:0] bin;
  logic [6:0] adj;

  always_comb begin
    valid = bcd_ok(hours_bcd) && (hours_bcd <= 8'h23);
    bin = 7'(hours_bcd[7:4]) * 7'd10 + 7'(hours_bcd[3:0]);
    adj = bin;
    hours_12_bcd = hours_bcd;
    pm = 1'b0;
    if (!valid) begin
      hours_12_bcd = {BLANK_CODE, BLANK_CODE};
    end else if (bin == 7'd0) begin
      hours_12_bcd = 8'h12;
    end else if (bin >= 7'd12) begin
      pm = 1'b1;
      adj = (bin == 7'd12) ? 7'd12 : bin - 7'd12;
      if (adj >= 7'd10)
        hours_12_bcd = {4'd1, 4'(adj - 7'd10)};
      else
        hours_12_bcd = {4'd0, adj[3:0]};
    end
  end

endmodule

// File: rtl/display_refresh_ctrl.sv
// Snapshots and formats BCD time for output_wrapper.
// One start strobe per update; outputs frozen while busy.
module display_refresh_ctrl
  import clock_display_pkg::*;
#(
  parameter int unsigned SYS_CLK_HZ = 50_000_000,
  parameter int unsigned REFRESH_HZ = 100,
  parameter int unsigned BLINK_HZ   = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_display_en,
  input  logic       i_time_stb,
  input  logic       i_mode_12h,
  input  logic [1:0] i_set_field,
  input  logic [7:0] i_hours_bcd,
  input  logic [7:0] i_minutes_bcd,
  input  logic [7:0] i_seconds_bcd,
  input  logic       i_busy,
  output logic       o_start_stb,
  output logic       o_en,
  output logic [3:0] o_hours_msb,
  output logic [3:0] o_hours_lsb,
  output logic [3:0] o_minutes_msb,
  output logic [3:0] o_minutes_lsb,
  output logic [3:0] o_seconds_msb,
  output logic [3:0] o_seconds_lsb,
  output logic       o_dp_hours1,
  output logic       o_dp_hours2,
  output logic       o_dp_minutes1,
  output logic       o_dp_minutes2,
  output logic       o_dp_seconds1,
  output logic       o_dp_seconds2
);

  localparam int unsigned REF_MAX = SYS_CLK_HZ / REFRESH_HZ - 1;
  localparam int unsigned BLK_MAX = SYS_CLK_HZ / (2 * BLINK_HZ) - 1;
  localparam int REF_W = (REF_MAX > 0) ? $clog2(REF_MAX + 1) : 1;
  localparam int BLK_W = (BLK_MAX > 0) ? $clog2(BLK_MAX + 1) : 1;

  state_e           state_q, state_d;
  logic [REF_W-1:0] ref_cnt;
  logic [BLK_W-1:0] blk_cnt;
  logic [1:0]       ack_cnt;
  logic             pending, blink_phase;
  logic             prev_en, prev_mode;
  logic [1:0]       prev_field;
  logic             refresh_tick, blink_tick, set_evt;

  assign refresh_tick = (ref_cnt == REF_W'(REF_MAX));
  assign blink_tick   = (blk_cnt == BLK_W'(BLK_MAX));
  assign set_evt = refresh_tick | blink_tick | i_time_stb
                 | (i_display_en != prev_en)
                 | (i_mode_12h != prev_mode)
                 | (i_set_field != prev_field);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      ref_cnt     <= '0;
      blk_cnt     <= '0;
      ack_cnt     <= '0;
      pending     <= 1'b1;
      blink_phase <= 1'b1;
      prev_en     <= 1'b0;
      prev_mode   <= 1'b0;
      prev_field  <= 2'd0;
    end else begin
      state_q    <= state_d;
      ref_cnt    <= refresh_tick ? '0 : ref_cnt + REF_W'(1);
      blk_cnt    <= blink_tick ? '0 : blk_cnt + BLK_W'(1);
      prev_en    <= i_display_en;
      prev_mode  <= i_mode_12h;
      prev_field <= i_set_field;
      if (blink_tick)
        blink_phase <= ~blink_phase;
      // A new event in the LOAD cycle must survive the clear.
      pending <= set_evt | (pending & (state_q != ST_LOAD));
      if (state_q == ST_START)
        ack_cnt <= '0;
      else if (state_q == ST_WAIT_ACK)
        ack_cnt <= ack_cnt + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (pending && !i_busy) state_d = ST_LOAD;
      ST_LOAD:      state_d = ST_START;
      ST_START:     state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (i_busy)               state_d = ST_WAIT_DONE;
        else if (ack_cnt == 2'd3) state_d = ST_IDLE;
      end
      ST_WAIT_DONE: if (!i_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  logic [7:0] h12;
  logic       h_pm, h_valid;

  hours_12h_conv u_conv (
    .hours_bcd   (i_hours_bcd),
    .hours_12_bcd(h12),
    .pm          (h_pm),
    .valid       (h_valid)
  );

  set_field_e field;
  logic       blank_now, colon_d, pm_d;
  logic [7:0] hours_d, minutes_d, seconds_d;

  always_comb begin
    field     = set_field_e'(i_set_field);
    blank_now = ~blink_phase;
    hours_d   = i_mode_12h ? h12 : i_hours_bcd;
    minutes_d = i_minutes_bcd;
    seconds_d = i_seconds_bcd;
    if (i_mode_12h && hours_d[7:4] == 4'd0)
      hours_d[7:4] = BLANK_CODE;
    if (!h_valid || (blank_now && field == FIELD_HOURS))
      hours_d = {BLANK_CODE, BLANK_CODE};
    if (!bcd_ok(i_minutes_bcd) || (blank_now && field == FIELD_MINUTES))
      minutes_d = {BLANK_CODE, BLANK_CODE};
    if (!bcd_ok(i_seconds_bcd) || (blank_now && field == FIELD_SECONDS))
      seconds_d = {BLANK_CODE, BLANK_CODE};
    colon_d = (field != FIELD_NONE) || !i_seconds_bcd[0];
    pm_d    = i_mode_12h && h_pm;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_start_stb   <= 1'b0;
      o_en          <= 1'b0;
      o_hours_msb   <= '0;
      o_hours_lsb   <= '0;
      o_minutes_msb <= '0;
      o_minutes_lsb <= '0;
      o_seconds_msb <= '0;
      o_seconds_lsb <= '0;
      o_dp_hours2   <= 1'b0;
      o_dp_minutes2 <= 1'b0;
      o_dp_seconds2 <= 1'b0;
    end else begin
      o_start_stb <= (state_d == ST_START);
      if (state_q == ST_LOAD) begin
        o_en          <= i_display_en;
        o_hours_msb   <= hours_d[7:4];
        o_hours_lsb   <= hours_d[3:0];
        o_minutes_msb <= minutes_d[7:4];
        o_minutes_lsb <= minutes_d[3:0];
        o_seconds_msb <= seconds_d[7:4];
        o_seconds_lsb <= seconds_d[3:0];
        o_dp_hours2   <= colon_d;
        o_dp_minutes2 <= colon_d;
        o_dp_seconds2 <= pm_d;
      end
    end
  end

  assign o_dp_hours1   = 1'b0;
  assign o_dp_minutes1 = 1'b0;
  assign o_dp_seconds1 = 1'b0;

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// Directed bench for display_refresh_ctrl with scaled dividers.
// Blink half period is 2000 cycles; refresh never fires in the run.
module tb_display_refresh_ctrl;

  logic       clk = 1'b0;
  logic       i_reset, i_display_en, i_time_stb, i_mode_12h, i_busy;
  logic [1:0] i_set_field;
  logic [7:0] i_hours_bcd, i_minutes_bcd, i_seconds_bcd;
  logic       o_start_stb, o_en;
  logic [3:0] o_hours_msb, o_hours_lsb, o_minutes_msb;
  logic [3:0] o_minutes_lsb, o_seconds_msb, o_seconds_lsb;
  logic       o_dp_hours1, o_dp_hours2, o_dp_minutes1;
  logic       o_dp_minutes2, o_dp_seconds1, o_dp_seconds2;

  always #5 clk = ~clk;

  display_refresh_ctrl #(
    .SYS_CLK_HZ(100_000),
    .REFRESH_HZ(1),
    .BLINK_HZ  (25)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_display_en (i_display_en),
    .i_time_stb   (i_time_stb),
    .i_mode_12h   (i_mode_12h),
    .i_set_field  (i_set_field),
    .i_hours_bcd  (i_hours_bcd),
    .i_minutes_bcd(i_minutes_bcd),
    .i_seconds_bcd(i_seconds_bcd),
    .i_busy       (i_busy),
    .o_start_stb  (o_start_stb),
    .o_en         (o_en),
    .o_hours_msb  (o_hours_msb),
    .o_hours_lsb  (o_hours_lsb),
    .o_minutes_msb(o_minutes_msb),
    .o_minutes_lsb(o_minutes_lsb),
    .o_seconds_msb(o_seconds_msb),
    .o_seconds_lsb(o_seconds_lsb),
    .o_dp_hours1  (o_dp_hours1),
    .o_dp_hours2  (o_dp_hours2),
    .o_dp_minutes1(o_dp_minutes1),
    .o_dp_minutes2(o_dp_minutes2),
    .o_dp_seconds1(o_dp_seconds1),
    .o_dp_seconds2(o_dp_seconds2)
  );

  logic [30:0] obs;
  assign obs = {o_en, o_hours_msb, o_hours_lsb,
                o_minutes_msb, o_minutes_lsb,
                o_seconds_msb, o_seconds_lsb,
                o_dp_hours1, o_dp_hours2,
                o_dp_minutes1, o_dp_minutes2,
                o_dp_seconds1, o_dp_seconds2};

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [30:0] ev(input logic en,
                                     input logic [23:0] dig,
                                     input logic colon,
                                     input logic pm);
    return {en, dig, 1'b0, colon, 1'b0, colon, 1'b0, pm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  task automatic wait_stb(input int budget, output int lat);
    int n;
    lat = 0;
    n = 0;
    while (lat == 0 && n < budget) begin
      @(negedge clk);
      i_time_stb = 1'b0;
      n++;
      if (o_start_stb === 1'b1) lat = n;
    end
  endtask

  task automatic do_update(input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input logic mode,
                           input logic [1:0] fld, input logic en,
                           output int lat);
    @(negedge clk);
    i_hours_bcd   = h;
    i_minutes_bcd = m;
    i_seconds_bcd = s;
    i_mode_12h    = mode;
    i_set_field   = fld;
    i_display_en  = en;
    i_time_stb    = 1'b1;
    wait_stb(8, lat);
  endtask

  task automatic serve();
    i_busy = 1'b1;
    repeat (3) @(negedge clk);
    i_busy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int lat, t1, nstb;
  logic changed;

  initial begin
    i_reset = 1'b1;
    i_display_en = 0; i_time_stb = 0; i_mode_12h = 0; i_busy = 0;
    i_set_field = 0;
    i_hours_bcd = 0; i_minutes_bcd = 0; i_seconds_bcd = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {o_start_stb, obs}, 32'd0);
    i_reset = 1'b0;
    wait_stb(4, lat);
    chk("reset_first_stb", 32'(lat >= 1 && lat <= 3), 32'd1);
    serve();

    do_update(8'h23, 8'h59, 8'h58, 1'b1, 2'd0, 1'b1, lat);
    chk("lat_23_12h", lat, 3);
    chk("h23_12h", obs, ev(1, 24'h115958, 1, 1));
    serve();
    do_update(8'h23, 8'h59, 8'h58, 1'b0, 2'd0, 1'b1, lat);
    chk("h23_24h", obs, ev(1, 24'h235958, 1, 0));
    serve();
    do_update(8'h00, 8'h05, 8'h07, 1'b1, 2'd0, 1'b1, lat);
    chk("h00_12h", obs, ev(1, 24'h120507, 0, 0));
    serve();
    do_update(8'h12, 8'h00, 8'h30, 1'b1, 2'd0, 1'b1, lat);
    chk("h12_12h", obs, ev(1, 24'h120030, 1, 1));
    serve();
    do_update(8'h20, 8'h41, 8'h11, 1'b1, 2'd0, 1'b1, lat);
    chk("h20_12h", obs, ev(1, 24'hF84111, 0, 1));
    serve();
    do_update(8'h09, 8'h10, 8'h02, 1'b1, 2'd0, 1'b1, lat);
    chk("h09_12h", obs, ev(1, 24'hF91002, 1, 0));
    serve();
    do_update(8'h24, 8'h5A, 8'h00, 1'b1, 2'd0, 1'b1, lat);
    chk("bad_h24", obs, ev(1, 24'hFFFF00, 1, 0));
    serve();
    do_update(8'h1A, 8'h00, 8'hA0, 1'b0, 2'd0, 1'b1, lat);
    chk("bad_nibbles", obs, ev(1, 24'hFF00FF, 1, 0));
    serve();
    do_update(8'h05, 8'h33, 8'h44, 1'b0, 2'd0, 1'b1, lat);
    chk("h05_24h", obs, ev(1, 24'h053344, 1, 0));
    serve();

    do_update(8'h10, 8'h20, 8'h30, 1'b0, 2'd0, 1'b1, lat);
    chk("busy_pre", obs, ev(1, 24'h102030, 1, 0));
    i_busy = 1'b1;
    nstb = 0;
    changed = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      i_time_stb = (i == 10);
      if (i == 10) i_hours_bcd = 8'h11;
      if (i == 50) i_minutes_bcd = 8'h21;
      if (o_start_stb === 1'b1) nstb++;
      if (obs !== ev(1, 24'h102030, 1, 0)) changed = 1'b1;
    end
    chk("busy_no_stb", nstb, 0);
    chk("busy_hold", 32'(changed), 0);
    i_busy = 1'b0;
    wait_stb(6, lat);
    chk("busy_release_lat", lat, 3);
    chk("busy_release_val", obs, ev(1, 24'h112130, 1, 0));
    serve();

    do_update(8'h07, 8'h08, 8'h09, 1'b0, 2'd0, 1'b1, lat);
    chk("lock_first", obs, ev(1, 24'h070809, 0, 0));
    i_time_stb = 1'b1;
    wait_stb(12, lat);
    chk("lock_retrigger_lat", lat, 7);
    serve();

    do_update(8'h13, 8'h14, 8'h15, 1'b0, 2'd0, 1'b1, lat);
    i_reset = 1'b1;
    @(negedge clk);
    chk("mid_reset", {o_start_stb, obs}, 32'd0);
    i_reset = 1'b0;
    wait_stb(4, lat);
    chk("mid_reset_restart", 32'(lat >= 1 && lat <= 3), 32'd1);
    serve();

    do_update(8'h10, 8'h34, 8'h56, 1'b0, 2'd2, 1'b1, lat);
    chk("blink_start", obs, ev(1, 24'h103456, 1, 0));
    serve();
    wait_stb(2100, lat);
    t1 = cyc;
    chk("blink_off1", obs, ev(1, 24'h10FF56, 1, 0));
    serve();
    wait_stb(2100, lat);
    chk("blink_period1", cyc - t1, 2000);
    chk("blink_on", obs, ev(1, 24'h103456, 1, 0));
    t1 = cyc;
    serve();
    wait_stb(2100, lat);
    chk("blink_period2", cyc - t1, 2000);
    chk("blink_off2", obs, ev(1, 24'h10FF56, 1, 0));
    serve();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
